// File: rtl/data_path_muxs_pkg.sv
// Shared types for the fetch-stage next-PC logic: branch predictor counter
// encoding and the branch target buffer entry layout.
package data_path_muxs_pkg;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } bp_cnt_t;

   // Tag is stored zero-extended to 32 bits so the layout is independent of BTB depth.
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
      bp_cnt_t     cnt;
   } btb_entry_t;

   localparam bp_cnt_t BP_ALLOC_CNT = WEAK_T;
   localparam bp_cnt_t BP_RESET_CNT = WEAK_NT;

endpackage

// File: rtl/pc_if.sv
// Fetch-stage PC bundle: pipeline control, resolve-stage redirect and BTB
// update inputs, plus the fetch address and prediction outputs.
interface pc_if;

   logic        ihit;
   logic        stall;
   logic        redirect_en;
   logic [31:0] redirect_addr;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush_btb;
   logic [31:0] imemaddr;
   logic [31:0] next_imemaddr;
   logic        pred_taken;
   logic [31:0] pred_target;

   modport pc_predict (
      input  ihit, stall, redirect_en, redirect_addr,
      input  upd_en, upd_pc, upd_taken, upd_target, flush_btb,
      output imemaddr, next_imemaddr, pred_taken, pred_target
   );

   modport tb (
      output ihit, stall, redirect_en, redirect_addr,
      output upd_en, upd_pc, upd_taken, upd_target, flush_btb,
      input  imemaddr, next_imemaddr, pred_taken, pred_target
   );

endinterface

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup reads the registered array, so same-cycle updates appear next cycle.
module btb_table
   import data_path_muxs_pkg::*;
#(
   parameter int BTB_ENTRIES = 8
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] lookup_pc,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        flush,
   output logic        pred_taken,
   output logic [31:0] pred_target
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);

   btb_entry_t entries_q [BTB_ENTRIES];
   btb_entry_t entries_d [BTB_ENTRIES];

   btb_entry_t       lk_e;
   btb_entry_t       upd_e;
   logic             upd_hit;
   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] upd_idx;
   logic             unused_lsb;

   function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
      return pc[IDX_W+1:2];
   endfunction

   function automatic logic [31:0] pc_tag(input logic [31:0] pc);
      return pc >> (IDX_W + 2);
   endfunction

   function automatic bp_cnt_t cnt_inc(input bp_cnt_t c);
      case (c)
         STRONG_NT: return WEAK_NT;
         WEAK_NT:   return WEAK_T;
         default:   return STRONG_T;
      endcase
   endfunction

   function automatic bp_cnt_t cnt_dec(input bp_cnt_t c);
      case (c)
         STRONG_T: return WEAK_T;
         WEAK_T:   return WEAK_NT;
         default:  return STRONG_NT;
      endcase
   endfunction

   assign unused_lsb = ^{lookup_pc[1:0], upd_pc[1:0]};

   assign lk_idx  = pc_idx(lookup_pc);
   assign upd_idx = pc_idx(upd_pc);
   assign lk_e    = entries_q[lk_idx];
   assign upd_e   = entries_q[upd_idx];
   assign upd_hit = upd_e.valid && (upd_e.tag == pc_tag(upd_pc));

   always_comb begin
      pred_taken  = lk_e.valid && (lk_e.tag == pc_tag(lookup_pc)) &&
                    (lk_e.cnt inside {WEAK_T, STRONG_T});
      pred_target = pred_taken ? lk_e.target : 32'h0;
   end

   // Flush overrides any concurrent update; a not-taken miss leaves the table alone.
   always_comb begin
      entries_d = entries_q;
      if (flush) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            entries_d[i].valid = 1'b0;
            entries_d[i].cnt   = BP_RESET_CNT;
         end
      end else if (upd_en) begin
         if (upd_hit) begin
            entries_d[upd_idx].cnt = upd_taken ? cnt_inc(upd_e.cnt) : cnt_dec(upd_e.cnt);
            if (upd_taken) begin
               entries_d[upd_idx].target = upd_target;
            end
         end else if (upd_taken) begin
            entries_d[upd_idx].valid  = 1'b1;
            entries_d[upd_idx].tag    = pc_tag(upd_pc);
            entries_d[upd_idx].target = upd_target;
            entries_d[upd_idx].cnt    = BP_ALLOC_CNT;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            entries_q[i] <= '{valid: 1'b0, tag: 32'h0, target: 32'h0, cnt: BP_RESET_CNT};
         end
      end else begin
         entries_q <= entries_d;
      end
   end

endmodule

// File: rtl/pc_predict.sv
// Fetch program counter: resolve-stage redirect, pipeline hold, BTB-predicted
// target, or sequential PC+4, in that priority order.
module pc_predict
   import data_path_muxs_pkg::*;
#(
   parameter logic [31:0] PC_INIT     = 32'h00000000,
   parameter int          BTB_ENTRIES = 8
) (
   input logic CLK,
   input logic nRST,
   pc_if.pc_predict pcif
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] seq_pc;
   logic        bp_taken;
   logic [31:0] bp_target;

   btb_table #(
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .CLK         (CLK),
      .nRST        (nRST),
      .lookup_pc   (pc_q),
      .upd_en      (pcif.upd_en),
      .upd_pc      (pcif.upd_pc),
      .upd_taken   (pcif.upd_taken),
      .upd_target  (pcif.upd_target),
      .flush       (pcif.flush_btb),
      .pred_taken  (bp_taken),
      .pred_target (bp_target)
   );

   // Plain modulo-2^32 add: 0xFFFFFFFC wraps to 0.
   assign seq_pc = pc_q + 32'd4;

   always_comb begin
      pc_d = seq_pc;
      if (pcif.redirect_en) begin
         pc_d = pcif.redirect_addr;
      end else if (pcif.stall || !pcif.ihit) begin
         pc_d = pc_q;
      end else if (bp_taken) begin
         pc_d = bp_target;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pc_q <= PC_INIT;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pcif.imemaddr      = pc_q;
   assign pcif.next_imemaddr = seq_pc;
   assign pcif.pred_taken    = bp_taken;
   assign pcif.pred_target   = bp_target;

endmodule

// File: tb/tb_pc_predict.sv
// Directed bench for pc_predict: reset, hold, BTB allocate/train/evict/flush,
// redirect priority, counter saturation and PC wrap-around.
module tb_pc_predict;

   logic CLK;
   logic nRST;
   int   n_vec;
   int   n_err;

   pc_if pcif ();

   pc_predict #(
      .PC_INIT     (32'h00000000),
      .BTB_ENTRIES (8)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .pcif (pcif.pc_predict)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic upd(input logic en, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      pcif.upd_en     = en;
      pcif.upd_pc     = pc;
      pcif.upd_taken  = tk;
      pcif.upd_target = tgt;
   endtask

   task automatic redirect_to(input logic [31:0] addr);
      pcif.redirect_en   = 1'b1;
      pcif.redirect_addr = addr;
      tick();
      pcif.redirect_en   = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      nRST               = 1'b0;
      pcif.ihit          = 1'b0;
      pcif.stall         = 1'b0;
      pcif.redirect_en   = 1'b0;
      pcif.redirect_addr = 32'h0;
      pcif.flush_btb     = 1'b0;
      upd(1'b0, 32'h0, 1'b0, 32'h0);

      // Reset state and sequential fetch
      tick();
      chk("rst_pc", pcif.imemaddr, 32'h0);
      chk("rst_pred", {31'b0, pcif.pred_taken}, 32'h0);
      chk("rst_tgt", pcif.pred_target, 32'h0);
      chk("rst_next", pcif.next_imemaddr, 32'h4);
      nRST = 1'b1;
      pcif.ihit = 1'b1;
      chk("seq0", pcif.imemaddr, 32'h0);
      tick(); chk("seq4", pcif.imemaddr, 32'h4);
      tick(); chk("seq8", pcif.imemaddr, 32'h8);
      tick(); chk("seq12", pcif.imemaddr, 32'hC);
      tick(); chk("seq16", pcif.imemaddr, 32'h10);

      // Hold on stall and on missing ihit
      pcif.stall = 1'b1;
      tick(); chk("stall1", pcif.imemaddr, 32'h10);
      tick(); chk("stall2", pcif.imemaddr, 32'h10);
      tick(); chk("stall3", pcif.imemaddr, 32'h10);
      pcif.stall = 1'b0;
      pcif.ihit  = 1'b0;
      tick(); chk("noihit", pcif.imemaddr, 32'h10);
      pcif.ihit = 1'b1;
      tick(); chk("release", pcif.imemaddr, 32'h14);

      // Allocate 0x20 -> 0x100 and follow the prediction
      upd(1'b1, 32'h20, 1'b1, 32'h100);
      tick();
      upd(1'b0, 32'h0, 1'b0, 32'h0);
      chk("pc18", pcif.imemaddr, 32'h18);
      chk("pred18", {31'b0, pcif.pred_taken}, 32'h0);
      tick(); tick();
      chk("pc20", pcif.imemaddr, 32'h20);
      chk("pred20", {31'b0, pcif.pred_taken}, 32'h1);
      chk("tgt20", pcif.pred_target, 32'h100);
      tick(); chk("follow", pcif.imemaddr, 32'h100);

      // Two not-taken updates drop the prediction; retrain from strong-NT
      pcif.redirect_en = 1'b1;
      pcif.redirect_addr = 32'h20;
      upd(1'b1, 32'h20, 1'b0, 32'h0);
      tick();
      pcif.redirect_en = 1'b0;
      pcif.ihit = 1'b0;
      chk("redir20", pcif.imemaddr, 32'h20);
      chk("nt1", {31'b0, pcif.pred_taken}, 32'h0);
      tick(); chk("nt2", {31'b0, pcif.pred_taken}, 32'h0);
      upd(1'b1, 32'h20, 1'b1, 32'h100);
      tick(); chk("tk_from00", {31'b0, pcif.pred_taken}, 32'h0);
      tick(); chk("tk_from01", {31'b0, pcif.pred_taken}, 32'h1);
      upd(1'b0, 32'h0, 1'b0, 32'h0);

      // Redirect beats both stall and a taken prediction
      pcif.stall = 1'b1;
      pcif.ihit  = 1'b1;
      chk("pre_redir_pred", {31'b0, pcif.pred_taken}, 32'h1);
      redirect_to(32'h400);
      chk("redir_prio", pcif.imemaddr, 32'h400);
      pcif.stall = 1'b0;
      pcif.ihit  = 1'b0;

      // Aliasing, read-before-write, eviction
      redirect_to(32'h40);
      chk("alias_pred", {31'b0, pcif.pred_taken}, 32'h0);
      upd(1'b1, 32'h40, 1'b1, 32'h200);
      #1;
      chk("rbw_old", {31'b0, pcif.pred_taken}, 32'h0);
      tick();
      upd(1'b0, 32'h0, 1'b0, 32'h0);
      chk("alloc40", {31'b0, pcif.pred_taken}, 32'h1);
      chk("tgt40", pcif.pred_target, 32'h200);
      redirect_to(32'h20);
      chk("evict20", {31'b0, pcif.pred_taken}, 32'h0);
      chk("evict20_tgt", pcif.pred_target, 32'h0);

      // Flush wins over a simultaneous update
      pcif.flush_btb = 1'b1;
      upd(1'b1, 32'h20, 1'b1, 32'h300);
      redirect_to(32'h40);
      pcif.flush_btb = 1'b0;
      upd(1'b0, 32'h0, 1'b0, 32'h0);
      chk("flush_pc", pcif.imemaddr, 32'h40);
      chk("flush40", {31'b0, pcif.pred_taken}, 32'h0);
      redirect_to(32'h20);
      chk("flush_drop", {31'b0, pcif.pred_taken}, 32'h0);
      pcif.flush_btb = 1'b1;
      pcif.ihit = 1'b1;
      tick();
      pcif.flush_btb = 1'b0;
      pcif.ihit = 1'b0;
      chk("flush_adv", pcif.imemaddr, 32'h24);

      // Counter saturation on entry 0x84
      pcif.redirect_en = 1'b1;
      pcif.redirect_addr = 32'h84;
      upd(1'b1, 32'h84, 1'b1, 32'h500);
      tick();
      pcif.redirect_en = 1'b0;
      chk("alloc84", {31'b0, pcif.pred_taken}, 32'h1);
      chk("tgt84", pcif.pred_target, 32'h500);
      tick(); tick();
      upd(1'b1, 32'h84, 1'b1, 32'h600);
      tick();
      chk("sat_pred", {31'b0, pcif.pred_taken}, 32'h1);
      chk("tgt_ovr", pcif.pred_target, 32'h600);
      upd(1'b1, 32'h84, 1'b0, 32'h0);
      tick(); chk("st11_to10", {31'b0, pcif.pred_taken}, 32'h1);
      tick(); chk("st10_to01", {31'b0, pcif.pred_taken}, 32'h0);
      chk("st01_tgt", pcif.pred_target, 32'h0);
      upd(1'b1, 32'h84, 1'b1, 32'h600);
      tick(); chk("st01_to10", {31'b0, pcif.pred_taken}, 32'h1);
      upd(1'b0, 32'h0, 1'b0, 32'h0);

      // Asynchronous reset mid-cycle clears PC and BTB
      #2;
      nRST = 1'b0;
      #1;
      chk("async_pc", pcif.imemaddr, 32'h0);
      chk("async_pred", {31'b0, pcif.pred_taken}, 32'h0);
      tick();
      nRST = 1'b1;
      redirect_to(32'h84);
      chk("rst_btb", {31'b0, pcif.pred_taken}, 32'h0);

      // Wrap-around
      redirect_to(32'hFFFFFFFC);
      pcif.ihit = 1'b1;
      chk("wrap_next", pcif.next_imemaddr, 32'h0);
      tick(); chk("wrap_pc", pcif.imemaddr, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pc_predict.md
Name: pc_predict

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Replaces fixed PCSrc mux selection with a resolve-stage redirect plus an internal direct-mapped branch target buffer (BTB) of 2-bit saturating predictors.
- Issues imemaddr to the instruction cache, predicts taken branches/jumps at fetch, and is corrected by the execute stage on a mispredict.

Parameters:
- PC_INIT, 32'h00000000, reset value of the program counter.
- BTB_ENTRIES, 8, number of BTB entries; power of two, minimum 2.
- IDX_W, $clog2(BTB_ENTRIES), index width, derived; not to be overridden.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction fetch complete this cycle.
- stall  input  1  hazard hold from the pipeline; PC must not advance.
- redirect_en  input  1  execute stage detected a mispredict or unpredicted control transfer.
- redirect_addr  input  32  correct next PC.
- upd_en  input  1  a resolved branch/jump is written back to the BTB.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  resolved direction.
- upd_target  input  32  resolved target.
- flush_btb  input  1  invalidate all BTB entries.
- imemaddr  output  32  current fetch PC.
- next_imemaddr  output  32  imemaddr + 4, modulo 2^32.
- pred_taken  output  1  BTB predicts taken for imemaddr.
- pred_target  output  32  predicted target; 0 when pred_taken=0.

Behaviour:
- Clock and reset: single clock CLK; reset nRST is asynchronous, active-low.
- Reset values: imemaddr=PC_INIT; all BTB valid bits=0; counters=2'b01; so pred_taken=0 and pred_target=0.
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Lookup is combinational on imemaddr: pred_taken = valid & tag match & counter[1].
- PC register next-value priority, highest first:
  - (1) redirect_en → redirect_addr, applied regardless of ihit or stall.
  - (2) stall or !ihit → hold.
  - (3) pred_taken → pred_target.
  - (4) otherwise → next_imemaddr.
- Latency: one cycle from a redirect_en assertion to imemaddr = redirect_addr.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Increment on taken, decrement on not-taken, saturating at both ends.
- Update on upd_en:
  - Hit (valid and tag match): adjust counter; if upd_taken, overwrite the target.
  - Miss with upd_taken: allocate the entry (valid=1, new tag, target, counter=10), evicting the previous occupant.
  - Miss with !upd_taken: no change.
- Read-before-write: a lookup and an update to the same index in one cycle returns the old entry; the new contents are visible the next cycle.
- flush_btb together with upd_en: flush wins and the update is dropped. flush_btb does not touch imemaddr.
- Wrap-around: 32'hFFFFFFFC + 4 = 32'h00000000; next_imemaddr is never saturated.
- Reset mid-operation: the asynchronous clear takes effect immediately with no partial update.

Decomposition:
- data_path_muxs_pkg holds:
  - bp_cnt_t enum (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T).
  - btb_entry_t struct (valid, tag, target, cnt).
  - constants BP_ALLOC_CNT=WEAK_T and BP_RESET_CNT=WEAK_NT.
- pc_if gains a pc_predict modport and a matching tb modport carrying the new signals.
- One sub-module, btb_table, holds the entry array, combinational lookup, update/allocate/flush logic and the saturating counters. pc_predict keeps only the PC register and next-PC priority logic.

Test Plan:
- Reset: assert nRST=0 mid-run → imemaddr=0 immediately, pred_taken=0. Release with ihit=1 → sequence 0, 4, 8, 12.
- Hold: stall=1 or ihit=0 for 3 cycles at imemaddr=0x10 → stays 0x10. Release → 0x14.
- Allocation and prediction:
  - upd_en, upd_pc=0x20, upd_taken=1, upd_target=0x100 → next fetch of 0x20 shows pred_taken=1, pred_target=0x100, then imemaddr=0x100.
  - Two not-taken updates to 0x20 → pred_taken=0.
- Redirect priority: redirect_en=1, redirect_addr=0x400 while stall=1 and pred_taken=1 → imemaddr=0x400 the next cycle.
- Aliasing and flush (BTB_ENTRIES=8):
  - Entry for 0x20, lookup of 0x40 (same index, different tag) → pred_taken=0.
  - Allocate 0x40 → 0x20 is evicted.
  - flush_btb with simultaneous upd_en → all predictions 0.
- Wrap and counters:
  - imemaddr=0xFFFFFFFC with ihit → 0x00000000.
  - Four taken updates then one not-taken on one entry → counter 11 then 10, pred_taken stays 1.
